// File: rtl/move_collector.sv
// Move collector: walks all 64 squares, drains each square's move FIFO
// word and streams valid moves out over a valid/ready port.
module move_collector #(
  parameter int TIMEOUT   = 256,
  parameter int MAX_MOVES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [5:0]   sq_sel,
  input  logic         sq_done,
  input  logic [159:0] sq_fifo,
  output logic         rden,
  output logic         hold_all,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [14:0]  mv_data,
  output logic [7:0]   move_count,
  output logic         timeout_err,
  output logic         list_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CTR_MAX = CW'(TIMEOUT - 1);
  localparam logic [7:0]    MC_MAX  = 8'(MAX_MOVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_EMIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     sel_q, sel_d;
  logic [CW-1:0]  ctr_q, ctr_d;
  logic [3:0]     slot_q, slot_d;
  logic [159:0]   buf_q, buf_d;
  logic [7:0]     mc_q, mc_d;
  logic           terr_q, terr_d;
  logic           hold_q;
  logic [9:0]     cur;

  assign cur = buf_q[32'(slot_q) * 10 +: 10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ctr_q   <= '0;
      slot_q  <= '0;
      buf_q   <= '0;
      mc_q    <= '0;
      terr_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ctr_q   <= ctr_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      mc_q    <= mc_d;
      terr_q  <= terr_d;
      hold_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ctr_d     = ctr_q;
    slot_d    = slot_q;
    buf_d     = buf_q;
    mc_d      = mc_q;
    terr_d    = terr_q;
    rden      = 1'b0;
    mv_valid  = 1'b0;
    mv_data   = '0;
    list_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          sel_d   = '0;
          ctr_d   = '0;
          mc_d    = '0;
          terr_d  = 1'b0;
        end
      end
      S_WAIT: begin
        // done beats a same-cycle timeout
        if (sq_done) begin
          state_d = S_READ;
        end else if (ctr_q == CTR_MAX) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          ctr_d = ctr_q + CW'(1);
        end
      end
      S_READ: begin
        rden    = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        buf_d   = sq_fifo;
        slot_d  = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (cur[9]) begin
          mv_valid = 1'b1;
          mv_data  = {sel_q[2:0], sel_q[5:3], cur[8:0]};
        end
        if (!cur[9] || mv_ready) begin
          if (cur[9] && (mc_q != MC_MAX))
            mc_d = mc_q + 8'd1;
          if (slot_q == 4'd15)
            state_d = S_NEXT;
          else
            slot_d = slot_q + 4'd1;
        end
      end
      S_NEXT: begin
        if (sel_q == 6'd63) begin
          state_d = S_FIN;
        end else begin
          sel_d   = sel_q + 6'd1;
          ctr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_FIN: begin
        list_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sq_sel      = sel_q;
  assign hold_all    = hold_q;
  assign move_count  = mc_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: per-square done/fifo model behind
// the sq_sel mux, negedge monitor, immediate-assertion checks.
module tb_move_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   sq_sel;
  logic         sq_done;
  logic [159:0] sq_fifo;
  logic         rden;
  logic         hold_all;
  logic         mv_valid;
  logic         mv_ready;
  logic [14:0]  mv_data;
  logic [7:0]   move_count;
  logic         timeout_err;
  logic         list_done;

  logic         done_arr [64];
  logic [159:0] fifo_arr [64];

  assign sq_done = done_arr[sq_sel];
  assign sq_fifo = fifo_arr[sq_sel];

  move_collector dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sq_sel      (sq_sel),
    .sq_done     (sq_done),
    .sq_fifo     (sq_fifo),
    .rden        (rden),
    .hold_all    (hold_all),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_data     (mv_data),
    .move_count  (move_count),
    .timeout_err (timeout_err),
    .list_done   (list_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          rden_total;
  int          rden_sq [64];
  int          valid_cycles;
  int          stab_viol;
  logic [14:0] acc_q [$];
  logic [14:0] exp_q [$];
  logic        pv, pacc;
  logic [14:0] pd;

  always @(negedge clk) begin
    if (reset) begin
      pv   = 1'b0;
      pacc = 1'b0;
    end else begin
      if (rden) begin
        rden_total++;
        rden_sq[sq_sel]++;
      end
      if (mv_valid) valid_cycles++;
      if (pv && !pacc && (!mv_valid || mv_data != pd))
        stab_viol++;
      if (mv_valid && mv_ready) acc_q.push_back(mv_data);
      pv   = mv_valid;
      pacc = mv_valid && mv_ready;
      pd   = mv_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rden_total   = 0;
    valid_cycles = 0;
    stab_viol    = 0;
    for (int i = 0; i < 64; i++) rden_sq[i] = 0;
    acc_q.delete();
  endtask

  task automatic clear_sq();
    for (int i = 0; i < 64; i++) begin
      done_arr[i] = 1'b1;
      fifo_arr[i] = '0;
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!list_done && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("list_done_seen", {31'd0, list_done}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!mv_valid && n < 400) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mv_valid}, 32'd1);
  endtask

  task automatic build_exp();
    logic [9:0] s;
    logic [5:0] q;
    exp_q.delete();
    for (int sq = 0; sq < 64; sq++) begin
      q = 6'(sq);
      if (done_arr[sq]) begin
        for (int i = 0; i < 16; i++) begin
          s = fifo_arr[sq][i*10 +: 10];
          if (s[9]) exp_q.push_back({q[2:0], q[5:3], s[8:0]});
        end
      end
    end
  endtask

  task automatic cmp_moves(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      if (acc_q[i] !== exp_q[i]) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int          cyc;
    logic [14:0] d;
    reset    = 1'b1;
    start    = 1'b0;
    mv_ready = 1'b1;
    clear_sq();
    clear_mon();
    tick();
    tick();
    chk("rst_sq_sel", {26'd0, sq_sel}, 0);
    chk("rst_rden", {31'd0, rden}, 0);
    chk("rst_hold", {31'd0, hold_all}, 0);
    chk("rst_valid", {31'd0, mv_valid}, 0);
    chk("rst_data", {17'd0, mv_data}, 0);
    chk("rst_count", {24'd0, move_count}, 0);
    chk("rst_terr", {31'd0, timeout_err}, 0);
    chk("rst_ldone", {31'd0, list_done}, 0);
    reset = 1'b0;
    tick();

    // 1: empty board, 20 cycles per square
    clear_mon();
    start_pass();
    chk("t1_hold_on", {31'd0, hold_all}, 1);
    wait_done(3000, cyc);
    chk("t1_cycles", cyc, 64 * 20);
    chk("t1_hold_fin", {31'd0, hold_all}, 1);
    chk("t1_count", {24'd0, move_count}, 0);
    chk("t1_valid_cyc", valid_cycles, 0);
    chk("t1_rden", rden_total, 64);
    chk("t1_terr", {31'd0, timeout_err}, 0);
    tick();
    chk("t1_hold_off", {31'd0, hold_all}, 0);
    chk("t1_ldone_pulse", {31'd0, list_done}, 0);

    // 2: single move from e5
    clear_mon();
    fifo_arr[6'o44][9:0] = 10'b1_100_101_001;
    start_pass();
    wait_done(3000, cyc);
    chk("t2_cycles", cyc, 64 * 20);
    chk("t2_count", {24'd0, move_count}, 1);
    chk("t2_n", acc_q.size(), 1);
    d = (acc_q.size() > 0) ? acc_q[0] : 15'd0;
    chk("t2_data", {17'd0, d}, {17'd0, 15'b100_100_100_101_001});
    tick();

    // 3: slots 0,3,15 on square 0 with stalls
    clear_sq();
    clear_mon();
    fifo_arr[0][0*10 +: 10]  = 10'b1_001_010_011;
    fifo_arr[0][3*10 +: 10]  = 10'b1_111_000_101;
    fifo_arr[0][15*10 +: 10] = 10'b1_010_110_000;
    mv_ready = 1'b0;
    start_pass();
    for (int k = 0; k < 3; k++) begin
      wait_valid("t3_valid_up");
      d = mv_data;
      repeat (5) tick();
      chk("t3_valid_held", {31'd0, mv_valid}, 1);
      chk("t3_data_held", {17'd0, mv_data}, {17'd0, d});
      mv_ready = 1'b1;
      tick();
      mv_ready = 1'b0;
    end
    mv_ready = 1'b1;
    wait_done(3000, cyc);
    build_exp();
    cmp_moves("t3_moves");
    chk("t3_stab", stab_viol, 0);
    chk("t3_count", {24'd0, move_count}, 3);
    tick();

    // 4: square 7 never done
    clear_sq();
    clear_mon();
    done_arr[7] = 1'b0;
    start_pass();
    wait_done(3000, cyc);
    chk("t4_cycles", cyc, 63 * 20 + 256 + 1);
    chk("t4_terr", {31'd0, timeout_err}, 1);
    chk("t4_rden_sq7", rden_sq[7], 0);
    chk("t4_rden", rden_total, 63);
    tick();
    done_arr[7] = 1'b1;

    // 5: reset while a move is pending
    clear_mon();
    fifo_arr[0][9:0] = 10'b1_101_011_110;
    mv_ready = 1'b0;
    start_pass();
    chk("t5_terr_clr", {31'd0, timeout_err}, 0);
    wait_valid("t5_valid_up");
    reset = 1'b1;
    #1;
    chk("t5_valid_rst", {31'd0, mv_valid}, 0);
    chk("t5_hold_rst", {31'd0, hold_all}, 0);
    chk("t5_rden_rst", {31'd0, rden}, 0);
    chk("t5_sel_rst", {26'd0, sq_sel}, 0);
    tick();
    reset = 1'b0;
    tick();
    clear_mon();
    mv_ready = 1'b1;
    start_pass();
    wait_done(3000, cyc);
    chk("t5_cycles", cyc, 64 * 20);
    chk("t5_rden", rden_total, 64);
    chk("t5_count", {24'd0, move_count}, 1);
    build_exp();
    cmp_moves("t5_moves");
    tick();

    // 6: 300 moves, count saturates
    clear_sq();
    clear_mon();
    for (int sq = 0; sq < 19; sq++)
      for (int i = 0; i < 16; i++)
        if (sq < 18 || i < 12)
          fifo_arr[sq][i*10 +: 10] = {1'b1, 9'(sq * 16 + i + 7)};
    start_pass();
    wait_done(3000, cyc);
    chk("t6_cycles", cyc, 64 * 20);
    chk("t6_count", {24'd0, move_count}, 255);
    build_exp();
    chk("t6_exp_n", exp_q.size(), 300);
    cmp_moves("t6_moves");
    chk("t6_stab", stab_viol, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
